dsp_frame_sequencer: RTL
========================

// Module: dsp_frame_sequencer
// PURPOSE
//  Sits in the DSP clock domain directly after the I2S->DSP CDC output.
//  Pairs the alternating L/R packets from the CDC into stereo frames.
//  Issues one start pulse per frame to the DSP effect core and waits for its done.
//  Flags frame overruns and core timeouts.
// PARAMETERS
//  PKT_WIDTH    16    width of one audio packet (one channel sample)
//  TIMEOUT_CYC  128   max clkDSP_i cycles in BUSY before abort (>=2)
//  CNT_WIDTH    16    width of frame counter
// PORTS
//  clkDSP_i          in   1          DSP-domain clock; the block's only clock
//  rstDSP_n_i        in   1          reset, asynchronous, active-low
//  pktDSP_i          in   PKT_WIDTH  packet from CDC, valid when pktChangedDSP_i=1
//  pktChangedDSP_i   in   1          1-cycle strobe: new packet on pktDSP_i
//  syncLeft_i        in   1          1-cycle strobe: next packet is Left (resync)
//  doneDSP_i         in   1          1-cycle strobe from core: frame finished
//  clrFlags_i        in   1          clears overrun_o and timeout_o
//  sampleL_o         out  PKT_WIDTH  Left sample of issued frame (registered)
//  sampleR_o         out  PKT_WIDTH  Right sample of issued frame (registered)
//  startDSP_o        out  1          1-cycle start strobe to core (registered)
//  busy_o            out  1          1 while in ISSUE or BUSY
//  overrun_o         out  1          sticky: a completed frame was overwritten
//  timeout_o         out  1          sticky: core missed doneDSP_i in time
//  frameCnt_o        out  CNT_WIDTH  frames issued, wraps at 2^CNT_WIDTH
// BEHAVIOUR
//  Reset
//  - All outputs are 0.
//  - FSM=IDLE, expectR=0, pairReady=0, staging/pending regs and counters 0.
//  Capture side (independent of FSM)
//  - pktChangedDSP_i & !expectR:
//    stageL<=pktDSP_i, expectR<=1.
//  - pktChangedDSP_i & expectR:
//    pendL<=stageL, pendR<=pktDSP_i, pairReady<=1, expectR<=0.
//  - syncLeft_i: expectR<=0 and any half pair is discarded.
//    If it coincides with pktChangedDSP_i, that packet is taken as Left.
//  - Overrun: a pair completes while pairReady=1 and the FSM is not consuming it
//    this cycle. The newest pair replaces pend, overrun_o<=1.
//  - Pair completes in the same cycle the FSM consumes:
//    the FSM takes the old pend value, the new pair is stored, pairReady stays 1.
//    No overrun is flagged.
//  FSM
//  - IDLE: if pairReady, consume (clear pairReady unless refilled) -> ISSUE.
//  - ISSUE (1 cycle):
//    sampleL_o/R_o<=pend values; startDSP_o=1; frameCnt_o++; busy_o=1; -> BUSY.
//  - BUSY: timer counts from 0 and busy_o=1.
//    - If doneDSP_i -> IDLE.
//    - Else if timer==TIMEOUT_CYC-1 -> timeout_o<=1, IDLE.
//    - doneDSP_i is ignored in IDLE and ISSUE.
//  Timing
//  - Latency: R strobe at cycle N -> pairReady at N+1 -> startDSP_o and new
//    sampleL_o/R_o at N+2 (if IDLE).
//  - Back-to-back frames: at best one ISSUE every 3 cycles
//    (ISSUE, BUSY with done, IDLE).
//  Outputs and flags
//  - sampleL_o/R_o hold their values until the next ISSUE.
//  - clrFlags_i clears both sticky flags. A set event in the same cycle wins
//    (flag reads 1).
//  - Asynchronous reset mid-frame returns everything to reset values.
//    The partial pair and pending pair are lost.
// TESTING
//  - Reset, send pkts 0x1111 then 0x2222 (R strobe at cycle N):
//    -> startDSP_o high at N+2 only; L=0x1111, R=0x2222; frameCnt_o=1.
//  - Core asserts done 5 cycles after start; send 3 frames spaced 20 cycles:
//    -> 3 starts, frameCnt_o=3, overrun_o=0, timeout_o=0.
//  - Hold core (no done), send pairs A/B, C/D, E/F:
//    -> A/B issued; E/F replaces C/D; overrun_o=1.
//    After TIMEOUT_CYC cycles, timeout_o=1 and E/F is issued.
//  - Send L=0xAAAA, then syncLeft_i, then 0xBBBB, 0xCCCC:
//    -> issued frame has L=0xBBBB, R=0xCCCC; 0xAAAA is never issued.
//  - R strobe in the same cycle the FSM consumes a pending pair:
//    -> no overrun; both frames are issued in order.
//  - Assert rstDSP_n_i low mid-BUSY:
//    -> outputs 0 immediately (async), no start is issued after release
//    until a new full pair arrives.

Source files
------------

// File: rtl/dsp_frame_sequencer_if.sv
// dsp_frame_sequencer_if: CDC packet input, DSP core handshake and status bundle for the frame sequencer.
interface dsp_frame_sequencer_if #(
  parameter int PKT_WIDTH = 16,
  parameter int CNT_WIDTH = 16
);
  logic [PKT_WIDTH-1:0] pktDSP_i;
  logic                 pktChangedDSP_i;
  logic                 syncLeft_i;
  logic                 doneDSP_i;
  logic                 clrFlags_i;
  logic [PKT_WIDTH-1:0] sampleL_o;
  logic [PKT_WIDTH-1:0] sampleR_o;
  logic                 startDSP_o;
  logic                 busy_o;
  logic                 overrun_o;
  logic                 timeout_o;
  logic [CNT_WIDTH-1:0] frameCnt_o;
  modport master (
    output pktDSP_i, pktChangedDSP_i, syncLeft_i, doneDSP_i, clrFlags_i,
    input  sampleL_o, sampleR_o, startDSP_o, busy_o, overrun_o, timeout_o, frameCnt_o
  );
  modport slave (
    input  pktDSP_i, pktChangedDSP_i, syncLeft_i, doneDSP_i, clrFlags_i,
    output sampleL_o, sampleR_o, startDSP_o, busy_o, overrun_o, timeout_o, frameCnt_o
  );
endinterface

// File: rtl/dsp_frame_sequencer.sv
// dsp_frame_sequencer: pairs L/R packets into stereo frames and hands one frame at a time to the DSP core.
module dsp_frame_sequencer #(
  parameter int PKT_WIDTH   = 16,
  parameter int TIMEOUT_CYC = 128,
  parameter int CNT_WIDTH   = 16
) (
  input logic                 clkDSP_i,
  input logic                 rstDSP_n_i,
  dsp_frame_sequencer_if.slave bus
);
  localparam int TW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TW-1:0] LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] BUSY  = 2'd2;

  logic [1:0]           state_q, state_d;
  logic [TW-1:0]        timer_q, timer_d;
  logic                 expect_r_q, expect_r_d;
  logic                 pair_ready_q, pair_ready_d;
  logic [PKT_WIDTH-1:0] stage_l_q, stage_l_d;
  logic [PKT_WIDTH-1:0] pend_l_q, pend_l_d;
  logic [PKT_WIDTH-1:0] pend_r_q, pend_r_d;
  logic [PKT_WIDTH-1:0] sample_l_q, sample_l_d;
  logic [PKT_WIDTH-1:0] sample_r_q, sample_r_d;
  logic                 start_q, start_d;
  logic                 overrun_q, overrun_d;
  logic                 timeout_q, timeout_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 exp_eff, complete, consume, timeout_hit;

  // A resync forces the current packet (if any) to be treated as Left.
  always_comb begin
    exp_eff      = expect_r_q & ~bus.syncLeft_i;
    complete     = bus.pktChangedDSP_i & exp_eff;
    consume      = (state_q == IDLE) & pair_ready_q;
    timeout_hit  = (state_q == BUSY) & ~bus.doneDSP_i & (timer_q == LAST);
    expect_r_d   = bus.pktChangedDSP_i ? ~exp_eff : exp_eff;
    stage_l_d    = (bus.pktChangedDSP_i & ~exp_eff) ? bus.pktDSP_i : stage_l_q;
    pend_l_d     = complete ? stage_l_q : pend_l_q;
    pend_r_d     = complete ? bus.pktDSP_i : pend_r_q;
    pair_ready_d = complete | (pair_ready_q & ~consume);
    overrun_d    = (complete & pair_ready_q & ~consume) | (overrun_q & ~bus.clrFlags_i);
    timeout_d    = timeout_hit | (timeout_q & ~bus.clrFlags_i);
    start_d      = consume;
    sample_l_d   = consume ? pend_l_q : sample_l_q;
    sample_r_d   = consume ? pend_r_q : sample_r_q;
    cnt_d        = cnt_q + CNT_WIDTH'(consume);
    timer_d      = (state_q == BUSY) ? timer_q + 1'b1 : '0;
    state_d      = consume ? ISSUE :
                   (state_q == ISSUE) ? BUSY :
                   ((state_q == BUSY) & (bus.doneDSP_i | timeout_hit)) ? IDLE : state_q;
  end

  always_ff @(posedge clkDSP_i or negedge rstDSP_n_i) begin
    if (!rstDSP_n_i) begin
      state_q      <= IDLE;
      timer_q      <= '0;
      expect_r_q   <= 1'b0;
      pair_ready_q <= 1'b0;
      stage_l_q    <= '0;
      pend_l_q     <= '0;
      pend_r_q     <= '0;
      sample_l_q   <= '0;
      sample_r_q   <= '0;
      start_q      <= 1'b0;
      overrun_q    <= 1'b0;
      timeout_q    <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      expect_r_q   <= expect_r_d;
      pair_ready_q <= pair_ready_d;
      stage_l_q    <= stage_l_d;
      pend_l_q     <= pend_l_d;
      pend_r_q     <= pend_r_d;
      sample_l_q   <= sample_l_d;
      sample_r_q   <= sample_r_d;
      start_q      <= start_d;
      overrun_q    <= overrun_d;
      timeout_q    <= timeout_d;
      cnt_q        <= cnt_d;
    end
  end

  assign bus.sampleL_o  = sample_l_q;
  assign bus.sampleR_o  = sample_r_q;
  assign bus.startDSP_o = start_q;
  assign bus.busy_o     = (state_q == ISSUE) | (state_q == BUSY);
  assign bus.overrun_o  = overrun_q;
  assign bus.timeout_o  = timeout_q;
  assign bus.frameCnt_o = cnt_q;
endmodule
